bsg_counter_set_down: RTL

BSG_COUNTER_SET_DOWN -- requirements
Module: bsg_counter_set_down

---
 rtl/bsg_counter_set_down_if.sv | 22 ++
 rtl/bsg_counter_set_down.sv | 73 +++++++
 2 files changed

// File: rtl/bsg_counter_set_down_if.sv
// Handshake bundle for bsg_counter_set_down: load/decrement requests in,
// registered count and status flags out.
interface bsg_counter_set_down_if #(parameter int width_p = 32);
    logic               set_i;
    logic [width_p-1:0] val_i;
    logic               down_i;
    logic [width_p-1:0] count_r_o;
    logic               zero_o;
    logic               busy_o;
    logic               expired_o;
    logic               underflow_o;

    modport master (
        output set_i, val_i, down_i,
        input  count_r_o, zero_o, busy_o, expired_o, underflow_o
    );

    modport slave (
        input  set_i, val_i, down_i,
        output count_r_o, zero_o, busy_o, expired_o, underflow_o
    );
endinterface

// File: rtl/bsg_counter_set_down.sv
// Loadable saturating down-counter with IDLE/RUN/DONE tracking, a one-cycle
// expiry pulse and a sticky underflow flag.
module bsg_counter_set_down #(
    parameter int                 width_p                  = 32,
    parameter logic [width_p-1:0] init_val_p               = '0,
    parameter bit                 set_and_down_exclusive_p = 1'b0
) (
    input logic                    clk_i,
    input logic                    reset_i,
    bsg_counter_set_down_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [width_p-1:0] one_lp         = width_p'(1);
    localparam state_e             reset_state_lp = (init_val_p != '0) ? RUN : IDLE;

    state_e             state, state_n;
    logic [width_p-1:0] count, count_n, base;
    logic               underflow, underflow_n;
    logic               dec, uf_event;

    // Load first, then decrement; a decrement that would cross zero saturates.
    always_comb begin
        base        = bus.set_i ? bus.val_i : count;
        dec         = bus.down_i && !(set_and_down_exclusive_p && bus.set_i);
        uf_event    = dec && (base == '0);
        count_n     = (dec && !uf_event) ? (base - one_lp) : base;
        underflow_n = underflow;
        if (uf_event)       underflow_n = 1'b1;
        else if (bus.set_i) underflow_n = 1'b0;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.set_i && count_n != '0) state_n = RUN;
            RUN: begin
                if (bus.set_i)                 state_n = (count_n != '0) ? RUN : IDLE;
                else if (dec && count == one_lp) state_n = DONE;
            end
            DONE:    state_n = (bus.set_i && count_n != '0) ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count     <= init_val_p;
            state     <= reset_state_lp;
            underflow <= 1'b0;
        end else begin
            count     <= count_n;
            state     <= state_n;
            underflow <= underflow_n;
        end
    end

    assign bus.count_r_o   = count;
    assign bus.zero_o      = (count == '0);
    assign bus.busy_o      = (state == RUN);
    assign bus.expired_o   = (state == DONE);
    assign bus.underflow_o = underflow;

    // Callers that promise exclusivity get flagged in simulation if they break it.
    generate
        if (set_and_down_exclusive_p) begin : g_excl
            excl_a: assert property (@(posedge clk_i) disable iff (reset_i)
                                     !(bus.set_i && bus.down_i));
        end
    endgenerate

endmodule
